// File: rtl/dmem_block_mover.sv
// dmem_block_mover: block copy / block fill initiator on the data memory port.
// Copies words via a one-word buffer (read, then write) or streams a fill pattern.
module dmem_block_mover #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int LEN_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              mode_i,
   input  logic [ADDR_W-1:0] src_i,
   input  logic [ADDR_W-1:0] dst_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic [DATA_W-1:0] fill_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic              r_en_o,
   output logic              w_en_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] wdata_o,
   input  logic [DATA_W-1:0] rdata_i,
   input  logic              dmem_error_i
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_FL,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(8);
   localparam logic [LEN_W-1:0]  ONE        = LEN_W'(1);

   state_t            r_state;
   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [LEN_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_buf;
   logic [DATA_W-1:0] r_fill;
   logic              r_busy;
   logic              r_done;
   logic              r_err;

   // Sequencer: pointers, word count, buffer and registered status flags.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_src   <= '0;
         r_dst   <= '0;
         r_cnt   <= '0;
         r_buf   <= '0;
         r_fill  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start_i) begin
                  r_src  <= src_i;
                  r_dst  <= dst_i;
                  r_cnt  <= len_i;
                  r_fill <= fill_i;
                  r_err  <= 1'b0;
                  if (len_i == '0) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else if (!mode_i) begin
                     r_state <= S_RD;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= S_FL;
                     r_busy  <= 1'b1;
                  end
               end
            end
            S_RD: begin
               if (dmem_error_i) begin
                  r_err   <= 1'b1;
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_buf   <= rdata_i;
                  r_state <= S_WR;
               end
            end
            S_WR, S_FL: begin
               if (dmem_error_i) begin
                  r_err   <= 1'b1;
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_src <= r_src + WORD_BYTES;
                  r_dst <= r_dst + WORD_BYTES;
                  r_cnt <= r_cnt - ONE;
                  if (r_cnt == ONE) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else if (r_state == S_WR) begin
                     r_state <= S_RD;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // Memory port decode; only the write enable looks at the range error.
   always_comb begin
      r_en_o  = 1'b0;
      w_en_o  = 1'b0;
      addr_o  = '0;
      wdata_o = '0;
      unique case (r_state)
         S_RD: begin
            r_en_o = 1'b1;
            addr_o = r_src;
         end
         S_WR: begin
            w_en_o  = ~dmem_error_i;
            addr_o  = r_dst;
            wdata_o = r_buf;
         end
         S_FL: begin
            w_en_o  = ~dmem_error_i;
            addr_o  = r_dst;
            wdata_o = r_fill;
         end
         default: ;
      endcase
   end

   assign busy_o = r_busy;
   assign done_o = r_done;
   assign err_o  = r_err;

endmodule

// File: tb/tb_dmem_block_mover.sv
// tb_dmem_block_mover: random and directed copy/fill runs against a
// sequential word-level model of the block move and a behavioural memory.
module tb_dmem_block_mover;

   localparam int MEM_WORDS = 128;
   localparam logic [63:0] MEM_SIZE = 64'(MEM_WORDS * 8);

   logic        clk;
   logic        rst_i;
   logic        start_i;
   logic        mode_i;
   logic [63:0] src_i;
   logic [63:0] dst_i;
   logic [15:0] len_i;
   logic [63:0] fill_i;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic        r_en_o;
   logic        w_en_o;
   logic [63:0] addr_o;
   logic [63:0] wdata_o;
   logic [63:0] rdata_i;
   logic        dmem_error_i;

   logic [63:0] mem      [MEM_WORDS];
   logic [63:0] init_mem [MEM_WORDS];
   logic [63:0] ref_mem  [MEM_WORDS];
   logic        do_init;

   typedef struct {
      bit          r;
      bit          w;
      logic [63:0] a;
      logic [63:0] d;
   } acc_t;

   acc_t tr[$];
   bit   ref_err;
   int   n_chk;
   int   n_fail;

   dmem_block_mover dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .mode_i       (mode_i),
      .src_i        (src_i),
      .dst_i        (dst_i),
      .len_i        (len_i),
      .fill_i       (fill_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o),
      .r_en_o       (r_en_o),
      .w_en_o       (w_en_o),
      .addr_o       (addr_o),
      .wdata_o      (wdata_o),
      .rdata_i      (rdata_i),
      .dmem_error_i (dmem_error_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural data memory: combinational read and range error.
   assign dmem_error_i = (addr_o >= MEM_SIZE);
   assign rdata_i = (addr_o < MEM_SIZE) ? mem[addr_o[9:3]] : 64'h0;

   always @(posedge clk) begin
      if (do_init) begin
         mem <= init_mem;
      end else if (w_en_o && addr_o < MEM_SIZE) begin
         mem[addr_o[9:3]] <= wdata_o;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit bad(input logic [63:0] a);
      return a >= MEM_SIZE;
   endfunction

   // Word-by-word reference: each word is read then written in order,
   // so overlapping ranges naturally replicate forward.
   task automatic model(input bit mode, input logic [63:0] src,
                        input logic [63:0] dst, input int len,
                        input logic [63:0] fill);
      logic [63:0] s, d, v;
      acc_t e;
      tr.delete();
      ref_err = 0;
      for (int i = 0; i < len; i++) begin
         s = src + 64'(i * 8);
         d = dst + 64'(i * 8);
         v = fill;
         if (!mode) begin
            e = '{r: 1, w: 0, a: s, d: 64'h0};
            tr.push_back(e);
            if (bad(s)) begin
               ref_err = 1;
               break;
            end
            v = ref_mem[s[9:3]];
         end
         if (bad(d)) begin
            e = '{r: 0, w: 0, a: d, d: v};
            tr.push_back(e);
            ref_err = 1;
            break;
         end
         e = '{r: 0, w: 1, a: d, d: v};
         tr.push_back(e);
         ref_mem[d[9:3]] = v;
      end
   endtask

   task automatic load_mem(input bit rnd);
      for (int i = 0; i < MEM_WORDS; i++)
         init_mem[i] = rnd ? {$urandom, $urandom} : 64'h0;
      @(negedge clk);
      do_init = 1;
      @(negedge clk);
      do_init = 0;
   endtask

   task automatic cmp_mem(input string tag);
      int nbad;
      nbad = 0;
      for (int i = 0; i < MEM_WORDS; i++)
         if (mem[i] !== ref_mem[i]) nbad++;
      chk(tag, 64'(nbad), 64'h0);
   endtask

   task automatic run_op(input bit mode, input logic [63:0] src,
                         input logic [63:0] dst, input int len,
                         input logic [63:0] fill, input bit inject);
      int  dc;
      bit  seen;
      ref_mem = mem;
      model(mode, src, dst, len, fill);
      dc = tr.size() + 1;
      @(negedge clk);
      start_i = 1;
      mode_i  = mode;
      src_i   = src;
      dst_i   = dst;
      len_i   = 16'(len);
      fill_i  = fill;
      @(posedge clk);
      #1 start_i = 0;
      seen = 0;
      for (int c = 1; c <= 300 && !seen; c++) begin
         @(negedge clk);
         if (inject && c == 3) start_i = 0;
         if (done_o) begin
            seen = 1;
            chk("done_cycle", 64'(c), 64'(dc));
            chk("err_at_done", 64'(err_o), 64'(ref_err));
            chk("busy_at_done", 64'(busy_o), 64'h0);
            chk("acc_at_done", 64'({r_en_o, w_en_o}), 64'h0);
         end else if (c <= tr.size()) begin
            chk("busy", 64'(busy_o), 64'h1);
            chk("err_mid", 64'(err_o), 64'h0);
            chk("r_en", 64'(r_en_o), 64'(tr[c-1].r));
            chk("w_en", 64'(w_en_o), 64'(tr[c-1].w));
            chk("addr", addr_o, tr[c-1].a);
            if (tr[c-1].w) chk("wdata", wdata_o, tr[c-1].d);
         end else begin
            seen = 1;
            chk("done_missing", 64'(c), 64'(dc));
         end
         if (inject && c == 2) begin
            start_i = 1;
            mode_i  = ~mode;
            src_i   = 64'h0;
            dst_i   = 64'h0;
            len_i   = 16'd5;
            fill_i  = '1;
         end
      end
      start_i = 0;
      repeat (2) begin
         @(negedge clk);
         chk("idle_busy", 64'(busy_o), 64'h0);
         chk("idle_done", 64'(done_o), 64'h0);
         chk("idle_acc", 64'({r_en_o, w_en_o}), 64'h0);
         chk("idle_addr", addr_o, 64'h0);
         chk("idle_err", 64'(err_o), 64'(ref_err));
      end
      cmp_mem("mem");
   endtask

   initial begin
      n_chk   = 0;
      n_fail  = 0;
      rst_i   = 1;
      start_i = 0;
      mode_i  = 0;
      src_i   = '0;
      dst_i   = '0;
      len_i   = '0;
      fill_i  = '0;
      do_init = 0;
      load_mem(1);
      @(negedge clk);
      chk("rst_busy", 64'(busy_o), 64'h0);
      chk("rst_done", 64'(done_o), 64'h0);
      chk("rst_err", 64'(err_o), 64'h0);
      chk("rst_acc", 64'({r_en_o, w_en_o}), 64'h0);
      chk("rst_addr", addr_o, 64'h0);
      chk("rst_wdata", wdata_o, 64'h0);
      rst_i = 0;

      // directed copy of three words
      for (int i = 0; i < MEM_WORDS; i++) init_mem[i] = 64'h0;
      init_mem[32] = 64'h1111111111111111;
      init_mem[33] = 64'h2222222222222222;
      init_mem[34] = 64'h3333333333333333;
      @(negedge clk);
      do_init = 1;
      @(negedge clk);
      do_init = 0;
      run_op(0, 64'h100, 64'h200, 3, 64'h0, 0);
      chk("copy_w0", mem[64], 64'h1111111111111111);
      chk("copy_w2", mem[66], 64'h3333333333333333);

      // fill, zero length, range error, ignored start, overlap
      run_op(1, 64'h0, 64'h40, 4, 64'hDEADBEEFCAFEF00D, 0);
      run_op(0, 64'h100, 64'h200, 0, 64'h0, 0);
      load_mem(1);
      run_op(0, 64'h100, MEM_SIZE - 64'h8, 3, 64'h0, 0);
      run_op(0, 64'h180, 64'h280, 3, 64'h0, 1);
      run_op(0, 64'h100, 64'h108, 4, 64'h0, 0);
      run_op(1, 64'h0, MEM_SIZE - 64'h10, 4, 64'h5A5A5A5A5A5A5A5A, 0);

      // randomized operations, some straying outside memory
      for (int k = 0; k < 12; k++) begin
         run_op(1'($urandom_range(0, 1)),
                64'($urandom_range(0, MEM_WORDS + 3)) * 64'h8,
                64'($urandom_range(0, MEM_WORDS + 3)) * 64'h8,
                int'($urandom_range(0, 6)),
                {$urandom, $urandom}, 0);
      end

      // reset in the middle of an 8-word copy
      load_mem(1);
      ref_mem = mem;
      @(negedge clk);
      start_i = 1;
      mode_i  = 0;
      src_i   = 64'h100;
      dst_i   = 64'h300;
      len_i   = 16'd8;
      @(posedge clk);
      #1 start_i = 0;
      repeat (5) @(negedge clk);
      chk("pre_rst_ren", 64'(r_en_o), 64'h1);
      rst_i = 1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_busy", 64'(busy_o), 64'h0);
      chk("mid_rst_done", 64'(done_o), 64'h0);
      chk("mid_rst_err", 64'(err_o), 64'h0);
      chk("mid_rst_acc", 64'({r_en_o, w_en_o}), 64'h0);
      chk("mid_rst_addr", addr_o, 64'h0);
      chk("mid_rst_wdata", wdata_o, 64'h0);
      rst_i = 0;
      ref_mem[96] = ref_mem[32];
      ref_mem[97] = ref_mem[33];
      cmp_mem("rst_mem");
      run_op(1, 64'h0, 64'h20, 2, 64'h0123456789ABCDEF, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_block_mover.md
# dmem_block_mover

Memory-side initiator that performs multi-word block copy and block fill on the Y86 data memory port. It drives the same read-enable/write-enable/address/data interface the data memory exposes, so it can be muxed onto the memory port in place of the execute/memory stage. It is intended for program loading, stack clearing and test setup. Reads are combinational on the memory side; writes commit on the memory's clock edge.

## Interface
- ADDR_W, 64, address width in bits, matches `ADDR_BUS`
- DATA_W, 64, data width in bits (one word = 8 bytes), matches `DATA_BUS`
- LEN_W, 16, width of the word-count input
- clk_i  input  1  clock; all state changes on posedge
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  request; sampled only in IDLE
- mode_i  input  1  0 = copy, 1 = fill
- src_i  input  ADDR_W  copy source byte address; ignored in fill mode
- dst_i  input  ADDR_W  destination byte address
- len_i  input  LEN_W  number of 8-byte words to move
- fill_i  input  DATA_W  fill pattern
- busy_o  output  1  operation in progress
- done_o  output  1  one-cycle completion pulse
- err_o  output  1  sticky error for the last operation
- r_en_o  output  1  memory read enable
- w_en_o  output  1  memory write enable
- addr_o  output  ADDR_W  memory byte address
- wdata_o  output  DATA_W  memory write data
- rdata_i  input  DATA_W  memory read data, valid in the same cycle as r_en_o
- dmem_error_i  input  1  memory address-range error; combinational function of addr_o

## Operation
- States: IDLE, RD, WR, FL, DONE.
- IDLE: if start_i=1, latch src/dst/len/mode/fill, clear err_o, and go to:
  - DONE if len_i=0;
  - else RD if mode_i=0;
  - else FL.
- IDLE with start_i=0: stay in IDLE.
- start_i in any other state is ignored and is not queued.
- RD: r_en_o=1, addr_o=src_ptr.
  - At the clock edge, capture rdata_i into a word buffer, then go to WR.
  - If dmem_error_i=1: set err_o, go to DONE, leave the buffer unchanged.
- WR: addr_o=dst_ptr, wdata_o=buffer, w_en_o = NOT dmem_error_i (a bad address is never written).
  - On success: src_ptr+=8, dst_ptr+=8, count-=1. Go to DONE if count was 1, else go to RD.
  - On error: set err_o, go to DONE.
- FL: same write rules as WR, with wdata_o=fill pattern and no read phase.
  - On success: dst_ptr+=8, count-=1.
  - Go to DONE on the last word or on error.
- DONE: done_o=1 for exactly one cycle, then go to IDLE.
- Pointer arithmetic is unsigned modulo 2^ADDR_W with no alignment check. Words are little-endian as delivered by memory; the block does not reorder bytes.
- Copy is strictly ascending. Overlapping ranges with dst > src replicate source words forward; this is defined behaviour, not an error.
- Outside RD/WR/FL:
  - r_en_o=0 and w_en_o=0;
  - addr_o and wdata_o are 0.
- busy_o=1 in RD, WR and FL; it is 0 in IDLE and DONE.
- Reset (at any time, including mid-operation): state IDLE, all outputs 0, err_o=0, pointers/count/buffer 0. An interrupted transfer leaves already-written words in memory.

## Timing
- Start accepted at edge T0. The first memory access is in cycle T0+1.
- Copy of N words: 2N access cycles, done_o in cycle T0+2N+1.
- Fill of N words: done_o in cycle T0+N+1.
- len=0: done_o in cycle T0+1, with no memory access.
- Error in access cycle k: done_o in cycle k+1, with err_o=1 from cycle k+1 until the next accepted start.
- A new start_i is accepted at the earliest in the IDLE cycle following DONE (back-to-back spacing: one DONE cycle plus one IDLE cycle).
- No combinational path from rdata_i to any output. The only input-to-output combinational path is dmem_error_i to w_en_o.

## Test plan
- Reset: assert rst_i for 2 cycles during a copy -> next cycle all outputs 0, busy_o=0; memory beyond the words already written is untouched.
- Copy: mem[0x100..0x117]={0x11..,0x22..,0x33..}, start copy src=0x100 dst=0x200 len=3 -> alternating r_en_o/w_en_o; addr sequence 0x100,0x200,0x108,0x208,0x110,0x210; done_o at T0+7; mem[0x200..0x217] matches the source; err_o=0.
- Fill: dst=0x40, len=4, fill=0xDEADBEEFCAFEF00D -> w_en_o high 4 consecutive cycles at 0x40,0x48,0x50,0x58; done_o at T0+5.
- Zero length: len=0 copy -> done_o at T0+1; r_en_o and w_en_o never asserted.
- Error: copy dst=MEM_SIZE-8, len=3, memory flags an error on the second write address -> first word written, second w_en_o suppressed, done_o the next cycle, err_o=1 held until the next start.
- Ignored start: pulse start_i with new arguments during busy -> the original operation completes unchanged; no second operation follows.
